// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, BCD digit width and double-dabble adjust constants.
package bcd_conv_pkg;

  localparam int DIGIT_W = 4;

  // Digits at or above this value are corrected before each shift.
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of the input digit.
// Ports: dig_in - current BCD digit (0..9); dig_out - corrected digit (0..12).
module bcd_digit_adjust
  import bcd_conv_pkg::*;
(
  input  logic [DIGIT_W-1:0] dig_in,
  output logic [DIGIT_W-1:0] dig_out
);

  // Inputs never exceed 9 in use, so the sum stays within 4 bits.
  assign dig_out = (dig_in >= ADJ_THRESH) ? (dig_in + ADJ_ADD) : dig_in;

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per cycle).
// Latency: resp_val rises NBITS+1 cycles after the accept cycle; 1 cycle when
//   BCD_CONV_FAST_EN is defined and the value is below 10.
// Backpressure: req_rdy only in IDLE; result held in DONE until resp_rdy.
// Ports: clk/rst (async active-high); req_val/req_rdy/req_msg request side;
//   resp_val/resp_rdy/resp_tens/resp_ones response side.
// Optional macro: BCD_CONV_FAST_EN - values 0..9 skip the shift phase.
module bcd_conv_ctrl
  import bcd_conv_pkg::*;
#(
  parameter int NBITS = 5  // legal 1..6 so the largest input fits in two digits
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [NBITS-1:0]   req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [DIGIT_W-1:0] resp_tens,
  output logic [DIGIT_W-1:0] resp_ones
);

  localparam int CNT_W = $clog2(NBITS + 1);

  state_e             state_q, state_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               resp_val_q, resp_val_d;

  logic [DIGIT_W-1:0] tens_adj, ones_adj;

`ifdef BCD_CONV_FAST_EN
  logic [7:0] msg_ext;
  assign msg_ext = 8'(req_msg);
`endif

  bcd_digit_adjust u_adj_tens (.dig_in(tens_q), .dig_out(tens_adj));
  bcd_digit_adjust u_adj_ones (.dig_in(ones_q), .dig_out(ones_adj));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (req_val) begin
          shreg_d = req_msg;
          tens_d  = '0;
          ones_d  = '0;
          cnt_d   = CNT_W'(NBITS);
          state_d = SHIFT;
`ifdef BCD_CONV_FAST_EN
          // A single-digit value is already its own BCD ones digit.
          if (msg_ext < 8'd10) begin
            ones_d  = msg_ext[DIGIT_W-1:0];
            state_d = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        // Correct both digits, then move the next binary MSB into ones.
        {tens_d, ones_d, shreg_d} = {tens_adj, ones_adj, shreg_q} << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    resp_val_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      cnt_q      <= '0;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      resp_val_q <= resp_val_d;
    end
  end

  // State resets to IDLE, so ready is masked while reset is still asserted.
  assign req_rdy   = (state_q == IDLE) && !rst;
  assign resp_val  = resp_val_q;
  assign resp_tens = tens_q;
  assign resp_ones = ones_q;

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Directed bench for bcd_conv_ctrl: reset, full sweep, stall, input change,
// mid-shift reset and (when BCD_CONV_FAST_EN is defined) the short path.
module tb_bcd_conv_ctrl;

  localparam int NBITS = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_val = 1'b0;
  logic             req_rdy;
  logic [NBITS-1:0] req_msg = '0;
  logic             resp_val;
  logic             resp_rdy = 1'b0;
  logic [3:0]       resp_tens;
  logic [3:0]       resp_ones;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_conv_ctrl #(.NBITS(NBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_msg   (req_msg),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_tens (resp_tens),
    .resp_ones (resp_ones)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int v);
`ifdef BCD_CONV_FAST_EN
    if (v < 10) return 1;
`endif
    return NBITS + 1;
  endfunction

  // Presents v until accepted; lat returns cycles from accept cycle to resp_val.
  task automatic send(input int v, output int lat);
    int guard;
    guard = 0;
    req_msg = NBITS'(v);
    req_val = 1'b1;
    while (!req_rdy && guard < 20) begin
      tick();
      guard++;
    end
    if (!req_rdy) chk("req_rdy_timeout", 0, 1);
    tick();
    req_val = 1'b0;
    lat = 1;
    while (!resp_val && lat < 40) begin
      tick();
      lat++;
    end
    if (!resp_val) chk("resp_val_timeout", 0, 1);
  endtask

  initial begin
    int lat;

    // Reset state while rst is held.
    #2;
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_tens", resp_tens, 0);
    chk("rst_ones", resp_ones, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle_req_rdy", req_rdy, 1);

    // 19: latency, digits, ready restored after handshake.
    resp_rdy = 1'b1;
    send(19, lat);
    chk("lat_19", lat, exp_lat(19));
    chk("tens_19", resp_tens, 1);
    chk("ones_19", resp_ones, 9);
    chk("done_req_rdy_19", req_rdy, 0);
    tick();
    chk("post_hs_req_rdy", req_rdy, 1);
    chk("post_hs_resp_val", resp_val, 0);
    chk("idle_hold_tens", resp_tens, 1);
    chk("idle_hold_ones", resp_ones, 9);

    // Back-to-back sweep of every input value.
    for (int v = 0; v < (1 << NBITS); v++) begin
      send(v, lat);
      chk($sformatf("sweep_lat_%0d", v), lat, exp_lat(v));
      chk($sformatf("sweep_tens_%0d", v), resp_tens, v / 10);
      chk($sformatf("sweep_ones_%0d", v), resp_ones, v % 10);
      tick();
    end

    // 27 with the consumer stalled for 5 cycles in DONE.
    resp_rdy = 1'b0;
    send(27, lat);
    chk("lat_27", lat, exp_lat(27));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_resp_val", resp_val, 1);
      chk("stall_tens", resp_tens, 2);
      chk("stall_ones", resp_ones, 7);
      chk("stall_req_rdy", req_rdy, 0);
    end
    resp_rdy = 1'b1;
    tick();
    chk("release_resp_val", resp_val, 0);
    chk("release_req_rdy", req_rdy, 1);

    // Input changed right after accept must not affect the result.
    req_msg = NBITS'(12);
    req_val = 1'b1;
    tick();
    req_val = 1'b0;
    req_msg = NBITS'(30);
    lat = 1;
    while (!resp_val && lat < 40) begin
      tick();
      lat++;
    end
    chk("chg_lat", lat, exp_lat(12));
    chk("chg_tens", resp_tens, 1);
    chk("chg_ones", resp_ones, 2);
    tick();

    // Reset two cycles into SHIFT for 22 aborts the conversion.
    req_msg = NBITS'(22);
    req_val = 1'b1;
    tick();
    req_val = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_resp_val", resp_val, 0);
    chk("abort_tens", resp_tens, 0);
    chk("abort_ones", resp_ones, 0);
    chk("abort_req_rdy", req_rdy, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_idle_rdy", req_rdy, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("abort_no_resp", resp_val, 0);
    end
    send(5, lat);
    chk("lat_5", lat, exp_lat(5));
    chk("tens_5", resp_tens, 0);
    chk("ones_5", resp_ones, 5);
    tick();

    // Short-path boundary values.
    send(7, lat);
    chk("lat_7", lat, exp_lat(7));
    chk("tens_7", resp_tens, 0);
    chk("ones_7", resp_ones, 7);
    tick();
    send(10, lat);
    chk("lat_10", lat, exp_lat(10));
    chk("tens_10", resp_tens, 1);
    chk("ones_10", resp_ones, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
